// File: rtl/pipe_pkg.sv
// Shared decode/execute pipeline definitions: ALUOp encodings, control-bundle width and bubble value.
package pipe_pkg;

  localparam int ALU_OP_W = 3;
  localparam int CTRL_W   = 7 + ALU_OP_W;

  localparam logic [ALU_OP_W-1:0] ALUOP_RTYPE = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALUOP_AND   = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALUOP_OR    = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALUOP_SLT   = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALUOP_LUI   = 3'd6;

  // A bubble carries no side effects: every control bit low.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Field-group register: async reset, enable holds on stall, synchronous clear inserts a bubble.
// Latency 1 cycle; clear has priority over a deasserted enable.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (clr)  q <= '0;
    else if (en)   q <= d;
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register, 1-cycle latency; flush > stall > load, stall holds everything.
// Optional ID_EX_BUBBLE_CNT_EN adds a saturating bubble counter on bubble_cnt_o.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = pipe_pkg::ALU_OP_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [DATA_W-1:0]     pc_plus4_i,
  input  logic [DATA_W-1:0]     rs_data_i,
  input  logic [DATA_W-1:0]     rt_data_i,
  input  logic [DATA_W-1:0]     imm_ext_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [4:0]            shamt_i,
  input  logic                  reg_write_i,
  input  logic                  mem_to_reg_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  branch_i,
  input  logic                  alu_src_i,
  input  logic                  reg_dst_i,
  input  logic [ALU_OP_W-1:0]   alu_op_i,
  output logic                  valid_o,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [31:0]           bubble_cnt_o,
`endif
  output logic [DATA_W-1:0]     pc_plus4_o,
  output logic [DATA_W-1:0]     rs_data_o,
  output logic [DATA_W-1:0]     rt_data_o,
  output logic [DATA_W-1:0]     imm_ext_o,
  output logic [REG_ADDR_W-1:0] rs_addr_o,
  output logic [REG_ADDR_W-1:0] rt_addr_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [4:0]            shamt_o,
  output logic                  reg_write_o,
  output logic                  mem_to_reg_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  branch_o,
  output logic                  alu_src_o,
  output logic                  reg_dst_o,
  output logic [ALU_OP_W-1:0]   alu_op_o
);

  localparam int CW = 7 + ALU_OP_W;
  localparam int DW = 4 * DATA_W;
  localparam int AW = 3 * REG_ADDR_W + 5;

  logic          load_en;
  logic [CW-1:0] ctrl_d;
  logic [CW:0]   ctrl_q;
  logic [DW-1:0] data_q;
  logic [AW-1:0] addr_q;
  logic          valid_q;

  assign load_en = ~stall_i;

  // An invalid decode slot is captured with its control squashed so it can never retire.
  assign ctrl_d = valid_i ? {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i,
                             branch_i, alu_src_i, reg_dst_i, alu_op_i}
                          : CW'(CTRL_BUBBLE);

  pipe_field_reg #(.W(CW + 1)) u_ctrl (
    .clk(clk_i), .rst(rst_i), .en(load_en), .clr(flush_i),
    .d({valid_i, ctrl_d}), .q(ctrl_q)
  );

  pipe_field_reg #(.W(DW)) u_data (
    .clk(clk_i), .rst(rst_i), .en(load_en), .clr(flush_i),
    .d({pc_plus4_i, rs_data_i, rt_data_i, imm_ext_i}), .q(data_q)
  );

  pipe_field_reg #(.W(AW)) u_addr (
    .clk(clk_i), .rst(rst_i), .en(load_en), .clr(flush_i),
    .d({rs_addr_i, rt_addr_i, rd_addr_i, shamt_i}), .q(addr_q)
  );

  assign valid_q = ctrl_q[CW];
  assign valid_o = valid_q;

  assign {pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o} = data_q;
  assign {rs_addr_o, rt_addr_o, rd_addr_o, shamt_o}    = addr_q;

  // Side-effecting controls are gated by the registered valid as a second line of defence.
  assign reg_write_o  = ctrl_q[CW-1] & valid_q;
  assign mem_to_reg_o = ctrl_q[CW-2];
  assign mem_read_o   = ctrl_q[CW-3] & valid_q;
  assign mem_write_o  = ctrl_q[CW-4] & valid_q;
  assign branch_o     = ctrl_q[CW-5] & valid_q;
  assign alu_src_o    = ctrl_q[CW-6];
  assign reg_dst_o    = ctrl_q[CW-7];
  assign alu_op_o     = ctrl_q[ALU_OP_W-1:0];

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
  logic        bubble_evt;

  assign bubble_evt = flush_i | (~stall_i & ~valid_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              bubble_cnt <= '0;
    else if (bubble_evt && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
  end

  assign bubble_cnt_o = bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg: reset, load, stall, flush, invalid load, back-to-back.
module tb_id_ex_pipe_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid;
  logic [31:0] pc_plus4, rs_data, rt_data, imm_ext;
  logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
  logic        reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst;
  logic [2:0]  alu_op;

  logic        valid_o;
  logic [31:0] pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o, shamt_o;
  logic        reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, branch_o, alu_src_o, reg_dst_o;
  logic [2:0]  alu_op_o;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .pc_plus4_i(pc_plus4), .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_ext_i(imm_ext),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr), .shamt_i(shamt),
    .reg_write_i(reg_write), .mem_to_reg_i(mem_to_reg), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .branch_i(branch), .alu_src_i(alu_src), .reg_dst_i(reg_dst),
    .alu_op_i(alu_op),
    .valid_o(valid_o),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt_o(bubble_cnt_o),
`endif
    .pc_plus4_o(pc_plus4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_ext_o(imm_ext_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o), .shamt_o(shamt_o),
    .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .branch_o(branch_o), .alu_src_o(alu_src_o), .reg_dst_o(reg_dst_o),
    .alu_op_o(alu_op_o)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; valid = 1'b1;
    pc_plus4 = 32'h0040_0004; rs_data = 32'hA5A5_0001; rt_data = 32'h5A5A_0002;
    imm_ext = 32'h0000_0010; rs_addr = 5'd3; rt_addr = 5'd4; rd_addr = 5'd5; shamt = 5'd7;
    reg_write = 1'b1; mem_to_reg = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    branch = 1'b1; alu_src = 1'b1; reg_dst = 1'b1; alu_op = ALUOP_SUB;
    tick();
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_hold_valid got=%0b exp=0", valid_o); end
    rst = 1'b0;
    tick();
    checks++; if (rs_data_o !== 32'hA5A5_0001 || pc_plus4_o !== 32'h0040_0004 || shamt_o !== 5'd7) begin
      failures++; $display("FAIL first_load_data rs=%h pc=%h sh=%0d", rs_data_o, pc_plus4_o, shamt_o); end
    checks++; if (valid_o !== 1'b1 || reg_write_o !== 1'b1 || branch_o !== 1'b1 || alu_op_o !== ALUOP_SUB) begin
      failures++; $display("FAIL first_load_ctrl v=%0b rw=%0b br=%0b op=%0d", valid_o, reg_write_o, branch_o, alu_op_o); end
    // Assert reset mid-cycle: outputs clear before any edge.
    #2 rst = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0 || reg_write_o !== 1'b0 || alu_op_o !== 3'd0 || mem_to_reg_o !== 1'b0) begin
      failures++; $display("FAIL async_reset_ctrl v=%0b rw=%0b op=%0d mtr=%0b exp all 0", valid_o, reg_write_o, alu_op_o, mem_to_reg_o); end
    checks++; if (rs_data_o !== 32'h0 || pc_plus4_o !== 32'h0 || rd_addr_o !== 5'd0 || shamt_o !== 5'd0) begin
      failures++; $display("FAIL async_reset_data rs=%h pc=%h rd=%0d sh=%0d exp 0", rs_data_o, pc_plus4_o, rd_addr_o, shamt_o); end
    tick();
    checks++; if (rt_data_o !== 32'h0 || imm_ext_o !== 32'h0 || valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_over_edge rt=%h imm=%h v=%0b exp 0", rt_data_o, imm_ext_o, valid_o); end
    rst = 1'b0;
    tick();
    checks++; if (rt_data_o !== 32'h5A5A_0002 || rd_addr_o !== 5'd5 || valid_o !== 1'b1) begin
      failures++; $display("FAIL reload_after_reset rt=%h rd=%0d v=%0b", rt_data_o, rd_addr_o, valid_o); end
  endtask

  task automatic test_load_itype();
    valid = 1'b1; imm_ext = 32'hFFFF_8000; alu_src = 1'b1; reg_write = 1'b1;
    reg_dst = 1'b0; alu_op = ALUOP_ADD; mem_read = 1'b0; branch = 1'b0;
    tick();
    checks++; if (imm_ext_o !== 32'hFFFF_8000) begin failures++; $display("FAIL itype_imm got=%h exp=ffff8000", imm_ext_o); end
    checks++; if (alu_src_o !== 1'b1 || reg_write_o !== 1'b1 || valid_o !== 1'b1 || reg_dst_o !== 1'b0) begin
      failures++; $display("FAIL itype_ctrl src=%0b rw=%0b v=%0b rd=%0b exp 1 1 1 0", alu_src_o, reg_write_o, valid_o, reg_dst_o); end
  endtask

  task automatic test_stall();
    rs_data = 32'h1234_5678;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rs_data = 32'hDEAD_0000 + i; valid = 1'b0;
      tick();
      checks++; if (rs_data_o !== 32'h1234_5678 || valid_o !== 1'b1) begin
        failures++; $display("FAIL stall_hold_%0d rs=%h v=%0b exp 12345678 1", i, rs_data_o, valid_o); end
    end
    stall = 1'b0; valid = 1'b1; rs_data = 32'hCAFE_BABE;
    tick();
    checks++; if (rs_data_o !== 32'hCAFE_BABE) begin failures++; $display("FAIL stall_release got=%h exp=cafebabe", rs_data_o); end
  endtask

  task automatic test_flush_stall();
    valid = 1'b1; mem_write = 1'b1; rt_data = 32'h0BAD_F00D; pc_plus4 = 32'h0040_0100;
    tick();
    checks++; if (valid_o !== 1'b1 || mem_write_o !== 1'b1) begin
      failures++; $display("FAIL pre_flush v=%0b mw=%0b exp 1 1", valid_o, mem_write_o); end
    flush = 1'b1; stall = 1'b1;
    tick();
    checks++; if (valid_o !== 1'b0 || mem_write_o !== 1'b0 || reg_write_o !== 1'b0 || alu_src_o !== 1'b0) begin
      failures++; $display("FAIL flush_ctrl v=%0b mw=%0b rw=%0b src=%0b exp 0", valid_o, mem_write_o, reg_write_o, alu_src_o); end
    checks++; if (rs_data_o !== 32'h0 || rt_data_o !== 32'h0 || pc_plus4_o !== 32'h0 || imm_ext_o !== 32'h0) begin
      failures++; $display("FAIL flush_data rs=%h rt=%h pc=%h imm=%h exp 0", rs_data_o, rt_data_o, pc_plus4_o, imm_ext_o); end
    checks++; if (rd_addr_o !== 5'd0 || rs_addr_o !== 5'd0 || shamt_o !== 5'd0) begin
      failures++; $display("FAIL flush_addr rd=%0d rs=%0d sh=%0d exp 0", rd_addr_o, rs_addr_o, shamt_o); end
    flush = 1'b0; stall = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_invalid_load();
    valid = 1'b0; reg_write = 1'b1; mem_write = 1'b1; rd_addr = 5'd9; rs_data = 32'h0000_00AB;
    tick();
    checks++; if (rd_addr_o !== 5'd9 || rs_data_o !== 32'h0000_00AB) begin
      failures++; $display("FAIL invalid_data rd=%0d rs=%h exp 9 000000ab", rd_addr_o, rs_data_o); end
    checks++; if (reg_write_o !== 1'b0 || valid_o !== 1'b0 || mem_write_o !== 1'b0 || alu_op_o !== 3'd0) begin
      failures++; $display("FAIL invalid_ctrl rw=%0b v=%0b mw=%0b op=%0d exp 0", reg_write_o, valid_o, mem_write_o, alu_op_o); end
    mem_write = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    logic [2:0]  ops [3];
    pcs[0] = 32'h0000_1004; pcs[1] = 32'h0000_1008; pcs[2] = 32'h0000_100C;
    ops[0] = ALUOP_AND; ops[1] = ALUOP_OR; ops[2] = ALUOP_SLT;
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_plus4 = pcs[i]; alu_op = ops[i]; rt_addr = 5'(i + 20);
      tick();
      checks++; if (pc_plus4_o !== pcs[i] || alu_op_o !== ops[i] || rt_addr_o !== 5'(i + 20)) begin
        failures++; $display("FAIL b2b_%0d pc=%h op=%0d rt=%0d exp %h %0d %0d", i, pc_plus4_o, alu_op_o, rt_addr_o, pcs[i], ops[i], i + 20); end
    end
  endtask

`ifdef ID_EX_BUBBLE_CNT_EN
  task automatic test_bubble_cnt();
    rst = 1'b1; #1 rst = 1'b0;
    checks++; if (bubble_cnt_o !== 32'd0) begin failures++; $display("FAIL bcnt_reset got=%0d exp=0", bubble_cnt_o); end
    valid = 1'b1; flush = 1'b1; tick();
    flush = 1'b0; stall = 1'b1; valid = 1'b0; tick();
    stall = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; valid = 1'b0; tick();
    valid = 1'b1; tick();
    checks++; if (bubble_cnt_o !== 32'd3) begin failures++; $display("FAIL bcnt_three got=%0d exp=3", bubble_cnt_o); end
    force dut.bubble_cnt = 32'hFFFF_FFFF;
    #1 release dut.bubble_cnt;
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (bubble_cnt_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL bcnt_saturate got=%h exp=ffffffff", bubble_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_itype();
    test_stall();
    test_flush_stall();
    test_invalid_load();
    test_back_to_back();
`ifdef ID_EX_BUBBLE_CNT_EN
    test_bubble_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
